slink_crc16_stream: RTL and testbench
=====================================

Name: slink_crc16_stream

Overview:
- Parametrised, streaming CRC-16/MCRF4XX engine for the S-Link packet path.
  - Polynomial 0x1021, reflected.
  - Init 0xFFFF.
  - LSB-first, no final XOR.
- Processes NUM_BYTES bytes per beat under valid/ready flow control, with packet framing (sop/eop) and a partial final beat.
- Produces a per-packet result with a back-pressurable result handshake.
- Supports two modes:
  - Generate: TX side, outputs the CRC to append.
  - Check: RX side, payload plus received CRC are streamed and the zero residue is tested.

Parameters:
- NUM_BYTES, 4, bytes per input beat. Legal values: 1, 2, 4, 8.
- CRC_INIT, 16'hFFFF, CRC seed loaded at each sop.
- NB_W, $clog2(NUM_BYTES+1), width of in_nbytes. Derived; do not override.

Ports:
- clk  input  1  block clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  8*NUM_BYTES  beat data. Byte k is in_data[8k+7:8k]; byte 0 is first on the link.
- in_sop  input  1  first beat of packet.
- in_eop  input  1  last beat of packet.
- in_nbytes  input  NB_W  valid bytes on an eop beat (1..NUM_BYTES). 0 is read as NUM_BYTES. Ignored on non-eop beats.
- check_mode  input  1  sampled on the sop beat. 0 = generate, 1 = check.
- out_valid  output  1  result valid.
- out_ready  input  1  result accepted.
- out_crc  output  16  final CRC register value.
- out_ok  output  1  check mode: out_crc==16'h0000. Generate mode: always 1.
- err_framing  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async assert, sync deassert in the reset synchronizer upstream):
  - state=IDLE, crc=CRC_INIT.
  - out_valid=0, out_crc=16'h0000, out_ok=0, err_framing=0.
  - in_ready=1.
- in_ready = (state!=RESULT) || out_ready.
- A beat transfers when in_valid && in_ready.
- Per-byte step: crc' = reflected 0x8408 update over 8 bits, LSB first.
  - A beat applies bytes 0..n-1 in order, where n=NUM_BYTES, or in_nbytes on eop.
  - The result is combinational over the byte chain and registered in the same cycle.
- Latency: out_valid rises in the cycle after the eop beat transfers.
- States:
  - IDLE:
    - Transferred beat with sop: crc = step(CRC_INIT, beat); latch check_mode.
    - If eop is also set, go to RESULT; otherwise go to ACTIVE.
    - Transferred beat without sop: beat is dropped, err_framing pulses, stay in IDLE.
  - ACTIVE:
    - Beat without sop: crc = step(crc, beat); eop goes to RESULT.
    - Beat with sop: restart from CRC_INIT with this beat and pulse err_framing. The aborted packet produces no result.
  - RESULT:
    - out_valid=1; out_crc/out_ok are held stable until out_ready.
    - On out_ready: go to IDLE, or load a new packet if a sop beat transfers in the same cycle (back-to-back, zero bubble).
- out_* registers update only on entry to RESULT.
- in_valid=0 never changes crc or state.
- in_nbytes > NUM_BYTES on an eop beat: clamp to NUM_BYTES.
- Simulation only: X bits in the next-CRC value are forced to 0 before registering (`ifndef SYNTHESIS`).
- Reset mid-packet: the partial packet is discarded, with no result and no error pulse.

Decomposition:
- Package slink_crc16_pkg:
  - CRC16_POLY_REFL=16'h8408.
  - CRC16_INIT=16'hFFFF.
  - CRC16_RESIDUE=16'h0000.
  - State enum {IDLE, ACTIVE, RESULT}.
- Sub-module slink_crc16_byte_step: purely combinational, 16-bit crc in plus 8-bit data in, 16-bit crc out.
  - Instantiate NUM_BYTES times in a chain.
  - Select the tap at index n-1.

Test Plan:
- NUM_BYTES=4, generate mode, 24-byte vector FF 00 00 00 1E F0 1E C7 4F 82 78 C5 82 E0 8C 70 D2 3C 78 E9 FF 00 00 01 sent as 6 beats (sop on beat 0, eop on beat 5) -> out_crc=16'hE569, out_ok=1, out_valid one cycle after eop.
- Same vector with NUM_BYTES=1 (24 beats) and NUM_BYTES=8 (3 beats) -> out_crc=16'hE569 in both.
- NUM_BYTES=4, check mode, vector plus 69 E5 (26 bytes; last beat in_nbytes=2) -> out_crc=16'h0000, out_ok=1. Flip one payload bit -> out_ok=0, out_crc!=0.
- Back-pressure: hold out_ready=0 for 5 cycles in RESULT -> in_ready=0 throughout, out_crc stable. Release with a new sop beat presented -> result accepted and new packet started in the same cycle; second result correct.
- Framing errors:
  - Non-sop beat in IDLE -> err_framing pulse, no out_valid.
  - sop in ACTIVE after 3 beats, then the full vector -> err_framing pulse, single result 16'hE569.
- Assert reset_n low mid-packet -> all outputs at reset values immediately. A following clean packet -> 16'hE569.

Source files
------------

// File: rtl/slink_crc16_pkg.sv
// Shared constants and state encoding for the S-Link CRC-16/MCRF4XX stream engine.
package slink_crc16_pkg;

  localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE   = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESULT
  } crcState_e;

endpackage

// File: rtl/slink_crc16_byte_step.sv
// One byte of the reflected CRC-16 (poly 0x8408) update, LSB of the byte first.
module slink_crc16_byte_step
  import slink_crc16_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] work;

  // Fold the byte into the low half, then shift out eight bits through the reflected polynomial.
  always_comb begin
    work = crc_i ^ {8'h00, data_i};
    for (int b = 0; b < 8; b++) begin
      work = work[0] ? ((work >> 1) ^ CRC16_POLY_REFL) : (work >> 1);
    end
    crc_o = work;
  end

endmodule

// File: rtl/slink_crc16_stream.sv
// Streaming CRC-16/MCRF4XX engine: NUM_BYTES per beat, sop/eop framing, held result handshake.
module slink_crc16_stream
  import slink_crc16_pkg::*;
#(
  parameter int          NUM_BYTES = 4,
  parameter logic [15:0] CRC_INIT  = CRC16_INIT,
  parameter int          NB_W      = $clog2(NUM_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [NB_W-1:0]        in_nbytes,
  input  logic                   check_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_crc,
  output logic                   out_ok,
  output logic                   err_framing
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  crcState_e   state_q;
  logic [15:0] crc_q;
  logic        checkMode_q;
  logic        outValid_q;
  logic [15:0] outCrc_q;
  logic        outOk_q;
  logic        errFraming_q;

  logic [15:0] seed;
  logic [15:0] stepOut [NUM_BYTES];
  logic [IDX_W-1:0] tapIdx;
  logic [15:0] crcRaw;
  logic [15:0] crc_d;
  logic        xfer;
  logic        residueOk;

  assign in_ready = (state_q != RESULT) || out_ready;
  assign xfer     = in_valid && in_ready;

  // A sop beat always restarts from the seed, whatever state we are in.
  assign seed = in_sop ? CRC_INIT : crc_q;

  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_step
    logic [15:0] stepIn;
    if (k == 0) begin : g_first
      assign stepIn = seed;
    end else begin : g_next
      assign stepIn = stepOut[k-1];
    end
    slink_crc16_byte_step u_step (
      .crc_i  (stepIn),
      .data_i (in_data[8*k +: 8]),
      .crc_o  (stepOut[k])
    );
  end

  // Pick the chain tap after the last valid byte; 0 or an oversize count means a full beat.
  always_comb begin
    tapIdx = IDX_W'(NUM_BYTES - 1);
    if (in_eop && (in_nbytes != '0) && (int'(in_nbytes) < NUM_BYTES)) begin
      tapIdx = IDX_W'(int'(in_nbytes) - 1);
    end
  end

  assign crcRaw = stepOut[tapIdx];

`ifndef SYNTHESIS
  // Keep unknown data bits from poisoning the CRC register in simulation.
  always_comb begin
    crc_d = '0;
    for (int i = 0; i < 16; i++) begin
      crc_d[i] = (crcRaw[i] === 1'b1);
    end
  end
`else
  assign crc_d = crcRaw;
`endif

  assign residueOk = (crc_d == CRC16_RESIDUE);

  // Packet FSM: tracks framing, owns the running CRC and the registered result/error outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      crc_q        <= CRC_INIT;
      checkMode_q  <= 1'b0;
      outValid_q   <= 1'b0;
      outCrc_q     <= 16'h0000;
      outOk_q      <= 1'b0;
      errFraming_q <= 1'b0;
    end else begin
      errFraming_q <= 1'b0;
      if ((state_q == RESULT) && out_ready) begin
        outValid_q <= 1'b0;
        state_q    <= IDLE;
      end
      if (xfer) begin
        if (in_sop) begin
          crc_q        <= crc_d;
          checkMode_q  <= check_mode;
          errFraming_q <= (state_q == ACTIVE);
          if (in_eop) begin
            state_q    <= RESULT;
            outValid_q <= 1'b1;
            outCrc_q   <= crc_d;
            outOk_q    <= !check_mode || residueOk;
          end else begin
            state_q <= ACTIVE;
          end
        end else if (state_q == ACTIVE) begin
          crc_q <= crc_d;
          if (in_eop) begin
            state_q    <= RESULT;
            outValid_q <= 1'b1;
            outCrc_q   <= crc_d;
            outOk_q    <= !checkMode_q || residueOk;
          end
        end else begin
          errFraming_q <= 1'b1;
        end
      end
    end
  end

  assign out_valid   = outValid_q;
  assign out_crc     = outCrc_q;
  assign out_ok      = outOk_q;
  assign err_framing = errFraming_q;

endmodule

// File: tb/tb_slink_crc16_stream.sv
// Self-checking bench for slink_crc16_stream: table of packets plus framing/back-pressure/reset sequences.
module tb_slink_crc16_stream;

  localparam int NB  = 4;
  localparam int NBW = $clog2(NB + 1);

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [8*NB-1:0] in_data;
  logic            in_sop;
  logic            in_eop;
  logic [NBW-1:0]  in_nbytes;
  logic            check_mode;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_crc;
  logic            out_ok;
  logic            err_framing;

  slink_crc16_stream #(.NUM_BYTES(NB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_nbytes   (in_nbytes),
    .check_mode  (check_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_crc     (out_crc),
    .out_ok      (out_ok),
    .err_framing (err_framing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]     data [0:31];
    int             len;
    logic           cm;
    logic [NBW-1:0] nbFull;
    logic [15:0]    expCrc;
    logic           expOk;
  } pkt_t;

  typedef struct packed {
    logic [15:0] crc;
    logic        ok;
  } exp_t;

  exp_t       sbQ[$];
  exp_t       monExp;
  int         total = 0;
  int         bad = 0;
  int         errCount = 0;
  int         resultCount = 0;
  int         lastFirstStalls = 0;
  logic [7:0] specVec [0:23];
  pkt_t       tbl [10];

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Bit-serial reference CRC-16/MCRF4XX.
  function automatic logic [15:0] modelCrc(input pkt_t p);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < p.len; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ p.data[i][b];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  function automatic pkt_t newPkt(input logic cm, input logic [NBW-1:0] nbf);
    pkt_t p;
    for (int i = 0; i < 32; i++) p.data[i] = 8'h00;
    p.len    = 0;
    p.cm     = cm;
    p.nbFull = nbf;
    p.expCrc = 16'h0000;
    p.expOk  = 1'b1;
    return p;
  endfunction

  function automatic pkt_t specPkt(input bit withCrc, input logic cm, input logic [NBW-1:0] nbf,
                                   input logic [15:0] ec, input logic eo);
    pkt_t p;
    p = newPkt(cm, nbf);
    for (int i = 0; i < 24; i++) p.data[i] = specVec[i];
    p.len = 24;
    if (withCrc) begin
      p.data[24] = 8'h69;
      p.data[25] = 8'hE5;
      p.len      = 26;
    end
    p.expCrc = ec;
    p.expOk  = eo;
    return p;
  endfunction

  // Present one beat and hold it until it transfers, bounded by a stall budget.
  task automatic driveBeat(input logic sop, input logic eop, input logic [NBW-1:0] nb,
                           input logic [8*NB-1:0] d, input logic cm, output int stalls);
    bit done;
    in_valid   = 1'b1;
    in_sop     = sop;
    in_eop     = eop;
    in_nbytes  = nb;
    in_data    = d;
    check_mode = cm;
    stalls     = 0;
    done       = 1'b0;
    while (!done && stalls < 100) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else stalls++;
    end
    if (done) begin
      @(posedge clk);
      #1;
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL beat_timeout actual=stalled required=transfer");
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // Send a whole packet as beats; the expected result goes to the scoreboard with the eop beat.
  task automatic applyStimulus(input pkt_t p);
    int nBeats;
    int rem;
    int st;
    logic [8*NB-1:0] d;
    logic [NBW-1:0]  nb;
    nBeats = (p.len + NB - 1) / NB;
    for (int b = 0; b < nBeats; b++) begin
      rem = p.len - b * NB;
      for (int k = 0; k < NB; k++) d[8*k +: 8] = (k < rem) ? p.data[b*NB + k] : 8'hA5;
      nb = (rem >= NB) ? p.nbFull : NBW'(rem);
      if (b == nBeats - 1) sbQ.push_back({p.expCrc, p.expOk});
      driveBeat(b == 0, b == nBeats - 1, nb, d, (b == 0) ? p.cm : ~p.cm, st);
      if (b == 0) lastFirstStalls = st;
      if (b == nBeats - 1) checkOutput("latency_out_valid", {31'd0, out_valid}, 1);
    end
  endtask

  // Result monitor: pop the scoreboard whenever a result is accepted.
  always @(negedge clk) begin
    if (err_framing) errCount++;
    if (reset_n && out_valid && out_ready) begin
      resultCount++;
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result actual=%h required=none", out_crc);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("result_crc", {16'd0, out_crc}, {16'd0, monExp.crc});
        checkOutput("result_ok", {31'd0, out_ok}, {31'd0, monExp.ok});
      end
    end
  end

  initial begin
    pkt_t p;
    int   eb;
    int   rc;
    int   st;
    logic [8*NB-1:0] d;

    specVec = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7,
                8'h4F, 8'h82, 8'h78, 8'hC5, 8'h82, 8'hE0, 8'h8C, 8'h70,
                8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};

    tbl[0] = specPkt(0, 1'b0, NBW'(4), 16'hE569, 1'b1);
    tbl[1] = specPkt(0, 1'b0, NBW'(0), 16'hE569, 1'b1);
    tbl[2] = specPkt(0, 1'b0, NBW'(7), 16'hE569, 1'b1);
    tbl[3] = specPkt(1, 1'b1, NBW'(4), 16'h0000, 1'b1);
    p = specPkt(1, 1'b1, NBW'(4), 16'h0000, 1'b0);
    p.data[5] = p.data[5] ^ 8'h04;
    p.expCrc  = modelCrc(p);
    tbl[4] = p;
    p = newPkt(1'b0, NBW'(4));
    p.len = 1;
    p.data[0] = 8'h31;
    p.expCrc = modelCrc(p);
    tbl[5] = p;
    p = newPkt(1'b0, NBW'(4));
    p.len = 9;
    for (int i = 0; i < 9; i++) p.data[i] = 8'(8'h31 + i);
    p.expCrc = 16'h6F91;
    tbl[6] = p;
    p.cm = 1'b1;
    p.len = 11;
    p.data[9]  = 8'h91;
    p.data[10] = 8'h6F;
    p.expCrc = 16'h0000;
    p.expOk  = 1'b1;
    tbl[7] = p;
    p = newPkt(1'b0, NBW'(4));
    p.len = 5;
    for (int i = 0; i < 5; i++) p.data[i] = 8'($urandom);
    p.expCrc = modelCrc(p);
    tbl[8] = p;
    p = newPkt(1'b1, NBW'(4));
    p.len = 7;
    for (int i = 0; i < 7; i++) p.data[i] = 8'($urandom);
    p.expCrc = modelCrc(p);
    p.expOk  = (p.expCrc == 16'h0000);
    tbl[9] = p;

    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_nbytes = '0;
    in_data = '0; check_mode = 1'b0; out_ready = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 0);
    checkOutput("reset_out_crc", {16'd0, out_crc}, 0);
    checkOutput("reset_out_ok", {31'd0, out_ok}, 0);
    checkOutput("reset_err_framing", {31'd0, err_framing}, 0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] table of %0d packets", 10);
    for (int i = 0; i < 10; i++) applyStimulus(tbl[i]);
    @(posedge clk);
    #1;

    $display("[TB] back-pressure with zero-bubble restart");
    out_ready = 1'b0;
    applyStimulus(tbl[0]);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", {31'd0, in_ready}, 0);
      checkOutput("bp_out_valid_held", {31'd0, out_valid}, 1);
      checkOutput("bp_out_crc_stable", {16'd0, out_crc}, 32'h0000E569);
    end
    @(posedge clk);
    #1;
    rc = resultCount;
    out_ready = 1'b1;
    applyStimulus(tbl[6]);
    checkOutput("bp_restart_no_stall", lastFirstStalls, 0);
    @(posedge clk);
    #1;
    checkOutput("bp_two_results", resultCount - rc, 2);

    $display("[TB] non-sop beat in IDLE");
    eb = errCount;
    rc = resultCount;
    d  = 32'h11223344;
    driveBeat(1'b0, 1'b1, NBW'(4), d, 1'b0, st);
    checkOutput("idle_drop_err_pulse", {31'd0, err_framing}, 1);
    @(posedge clk);
    #1;
    checkOutput("idle_drop_err_one_cycle", {31'd0, err_framing}, 0);
    checkOutput("idle_drop_no_valid", {31'd0, out_valid}, 0);
    checkOutput("idle_drop_err_count", errCount - eb, 1);
    checkOutput("idle_drop_no_result", resultCount - rc, 0);

    $display("[TB] sop inside an active packet");
    eb = errCount;
    rc = resultCount;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < NB; k++) d[8*k +: 8] = specVec[b*NB + k];
      driveBeat(b == 0, 1'b0, NBW'(4), d, 1'b1, st);
    end
    applyStimulus(tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_err_count", errCount - eb, 1);
    checkOutput("abort_single_result", resultCount - rc, 1);

    $display("[TB] reset mid-packet");
    eb = errCount;
    rc = resultCount;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < NB; k++) d[8*k +: 8] = specVec[b*NB + k];
      driveBeat(b == 0, 1'b0, NBW'(4), d, 1'b0, st);
    end
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 0);
    checkOutput("midrst_out_crc", {16'd0, out_crc}, 0);
    checkOutput("midrst_out_ok", {31'd0, out_ok}, 0);
    checkOutput("midrst_err_framing", {31'd0, err_framing}, 0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst_no_err", errCount - eb, 0);
    checkOutput("midrst_one_result", resultCount - rc, 1);

    for (int i = 0; i < 50 && sbQ.size() != 0; i++) @(posedge clk);
    checkOutput("scoreboard_drained", sbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
